// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control FSM.
// Control encodings match the single-cycle datapath so its decoders are reused.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_OPIMM  = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_OP     = 3'd4,
    CLS_BRANCH = 3'd5
  } class_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_SHIFT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // FETCH and MEM are the only states that own the memory port.
  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/op_class_decoder.sv
// Combinational decode: opcode -> instruction class, and registered class +
// funct3 -> ALU operand/immediate/operation controls.
module op_class_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct_3_i,
  input  logic [2:0] cls_i,
  output logic [2:0] cls_o,
  output logic [2:0] imm_src_o,
  output logic       alu_src_o,
  output logic [1:0] alu_op_o
);

  class_t cls;
  assign cls = class_t'(cls_i);

  always_comb begin
    cls_o = CLS_NONE;
    case (opcode_i)
      OPC_LOAD:   cls_o = CLS_LOAD;
      OPC_OPIMM:  cls_o = CLS_OPIMM;
      OPC_STORE:  cls_o = CLS_STORE;
      OPC_OP:     cls_o = CLS_OP;
      OPC_BRANCH: cls_o = CLS_BRANCH;
      default:    cls_o = CLS_NONE;
    endcase
  end

  always_comb begin
    imm_src_o = IMM_I;
    alu_src_o = 1'b0;
    alu_op_o  = ALUOP_ADD;
    case (cls)
      CLS_OPIMM: begin
        alu_src_o = 1'b1;
        alu_op_o  = ALUOP_FUNCT;
        // SLLI/SRLI/SRAI carry a shamt field rather than a full I-immediate.
        if (funct_3_i == 3'b001 || funct_3_i == 3'b101) imm_src_o = IMM_SHIFT;
      end
      CLS_OP: alu_op_o = ALUOP_FUNCT;
      CLS_LOAD: alu_src_o = 1'b1;
      CLS_STORE: begin
        alu_src_o = 1'b1;
        imm_src_o = IMM_S;
      end
      CLS_BRANCH: begin
        alu_op_o  = ALUOP_BR;
        imm_src_o = IMM_B;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port, with a per-request wait timeout and a sticky FAULT state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct_3_i,
  input  logic       zero_i,
  input  logic       mem_rdy_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       adr_src_o,
  output logic       ir_wr_en_o,
  output logic       pc_wr_en_o,
  output logic       pc_src_o,
  output logic       reg_wr_en_o,
  output logic       alu_src_o,
  output logic [2:0] imm_src_o,
  output logic [1:0] alu_op_o,
  output logic       result_src_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  class_t            class_q, class_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic [2:0] dec_cls;
  logic [2:0] dec_imm_src;
  logic       dec_alu_src;
  logic [1:0] dec_alu_op;

  logic       req, we, adr, ir_wr, pc_wr, pc_src, reg_wr, alu_src, res_src;
  logic [2:0] imm_src;
  logic [1:0] alu_op;
  logic       timeout;

  op_class_decoder u_dec (
    .opcode_i  (opcode_i),
    .funct_3_i (funct_3_i),
    .cls_i     (class_q),
    .cls_o     (dec_cls),
    .imm_src_o (dec_imm_src),
    .alu_src_o (dec_alu_src),
    .alu_op_o  (dec_alu_op)
  );

  assign timeout = (wait_q == TIMEOUT_C);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FETCH;
      class_q <= CLS_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
    end
  end

  // Handshake: mem_req/mem_we/adr_src are pure functions of state and class,
  // so they hold steady from request until the mem_rdy_i cycle that completes
  // it; mem_rdy_i is only looked at in FETCH and MEM.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    req     = 1'b0;
    we      = 1'b0;
    adr     = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    pc_src  = 1'b0;
    reg_wr  = 1'b0;
    alu_src = 1'b0;
    imm_src = IMM_I;
    alu_op  = ALUOP_ADD;
    res_src = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req = 1'b1;
        if (mem_rdy_i) begin
          ir_wr   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        class_d = class_t'(dec_cls);
        state_d = (dec_cls == CLS_NONE) ? ST_FAULT : ST_EXEC;
      end
      ST_EXEC: begin
        alu_src = dec_alu_src;
        imm_src = dec_imm_src;
        alu_op  = dec_alu_op;
        case (class_q)
          CLS_OPIMM, CLS_OP:    state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_BRANCH: begin
            // BEQ/BLT/BLTU use funct3[0]=0; their inverses flip the flag.
            pc_wr   = 1'b1;
            pc_src  = zero_i ^ funct_3_i[0];
            state_d = ST_FETCH;
          end
          default:              state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        req     = 1'b1;
        adr     = 1'b1;
        we      = (class_q == CLS_STORE);
        alu_src = dec_alu_src;
        imm_src = dec_imm_src;
        alu_op  = dec_alu_op;
        if (mem_rdy_i) begin
          if (class_q == CLS_STORE) begin
            pc_wr   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_wr  = 1'b1;
        res_src = (class_q == CLS_LOAD);
        pc_wr   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // Count only while lingering in a memory state; any entry starts at zero.
    if (is_mem_state(state_q) && (state_d == state_q)) wait_d = wait_q + CNT_W'(1);
    else                                               wait_d = '0;
  end

  // Outputs are forced low while reset is held, dropping any live request.
  assign mem_req_o    = rst_n_i & req;
  assign mem_we_o     = rst_n_i & we;
  assign adr_src_o    = rst_n_i & adr;
  assign ir_wr_en_o   = rst_n_i & ir_wr;
  assign pc_wr_en_o   = rst_n_i & pc_wr;
  assign pc_src_o     = rst_n_i & pc_src;
  assign reg_wr_en_o  = rst_n_i & reg_wr;
  assign alu_src_o    = rst_n_i & alu_src;
  assign imm_src_o    = rst_n_i ? imm_src : 3'b000;
  assign alu_op_o     = rst_n_i ? alu_op : 2'b00;
  assign result_src_o = rst_n_i & res_src;
  assign fault_o      = rst_n_i & (state_q == ST_FAULT);
  assign state_o      = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences a single shared instruction/data memory port, the instruction register, PC update, ALU control and register-file writeback over FETCH/DECODE/EXEC/MEM/WB steps. It decodes opcode/funct3 into the same control encodings used by the single-cycle datapath, so the ALU decoder, immediate extender and register file are reused unchanged. It adds a memory request/ready handshake, a wait timeout and a sticky fault state.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_rdy_i in one FETCH/MEM visit before faulting (1..255)
CNT_W, 8, width of the wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
opcode_i  in  7  opcode from instruction register; valid from DECODE onward
funct_3_i  in  3  funct3 from instruction register
zero_i  in  1  ALU compare flag (branch condition result)
mem_rdy_i  in  1  memory completes current request this cycle
mem_req_o  out  1  memory request valid
mem_we_o  out  1  memory write (store)
adr_src_o  out  1  memory address select: 0 = PC, 1 = ALU result
ir_wr_en_o  out  1  latch fetched word into instruction register
pc_wr_en_o  out  1  update PC this cycle
pc_src_o  out  1  0 = PC+4, 1 = branch target
reg_wr_en_o  out  1  register file write enable
alu_src_o  out  1  0 = rs2, 1 = immediate
imm_src_o  out  3  immediate format: 000 I, 001 S, 010 B, 101 shift-imm
alu_op_o  out  2  00 add, 01 branch compare, 10 funct-decoded
result_src_o  out  1  writeback select: 0 = ALU, 1 = memory
fault_o  out  1  sticky; illegal opcode or memory timeout
state_o  out  3  current state, for debug/trace

Behaviour:
- Reset (async, rst_n_i=0): state=FETCH, wait counter=0, class=NONE, fault=0. All outputs read 0 while in reset. After release, FETCH asserts mem_req_o on the first clock.
- Outputs are Moore-decoded from state and the registered class, plus mem_rdy_i/zero_i qualifiers where listed.
- FETCH: mem_req_o=1, adr_src_o=0, mem_we_o=0. On mem_rdy_i: ir_wr_en_o=1 in the same cycle, next state DECODE.
- DECODE: one cycle. Register the class from opcode_i: LOAD 0000011, OPIMM 0010011, STORE 0100011, OP 0110011, BRANCH 1100011. Any other opcode goes to FAULT.
- EXEC: drive alu_src/imm_src/alu_op for the class.
  - OPIMM: alu_src=1, alu_op=10, imm_src=101 if funct3 is 001 or 101, else 000. Next WB.
  - OP: alu_src=0, alu_op=10. Next WB.
  - LOAD/STORE: alu_src=1, alu_op=00, imm_src=000 (LOAD) or 001 (STORE). Next MEM.
  - BRANCH: alu_src=0, alu_op=01, imm_src=010. taken = zero_i XOR funct_3_i[0]. pc_wr_en_o=1, pc_src_o=taken. Next FETCH.
- MEM: mem_req_o=1, adr_src_o=1, mem_we_o=1 for STORE; EXEC ALU controls held. On mem_rdy_i: STORE asserts pc_wr_en_o=1, pc_src_o=0 and goes to FETCH; LOAD goes to WB.
- WB: reg_wr_en_o=1, result_src_o=1 for LOAD else 0, pc_wr_en_o=1, pc_src_o=0. Next FETCH.
- Handshake: once mem_req_o rises, mem_req_o, mem_we_o and adr_src_o stay stable until the mem_rdy_i cycle. mem_rdy_i is ignored when mem_req_o=0. Each request completes in at most one cycle after ready.
- Timeout: counter clears on entry to FETCH/MEM and increments on each cycle without ready. If counter==MEM_TIMEOUT and mem_rdy_i=0, next state is FAULT. Ready on that same cycle wins (completes normally).
- FAULT: all enables 0, mem_req_o=0, fault_o=1. Held until reset; no self-recovery.
- No other output pulses: at most one of ir_wr_en_o/reg_wr_en_o is high per cycle, and pc_wr_en_o is high exactly once per retired instruction.
- Latency with zero-wait memory: OP/OPIMM 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Reset mid-request drops mem_req_o immediately (async); no partial write is guaranteed.

Decomposition:
- Package ctrl_pkg: state_t enum (FETCH, DECODE, EXEC, MEM, WB, FAULT), class_t enum, opcode constants, IMM_I/S/B/SHIFT and ALUOP_ADD/BR/FUNCT localparams.
- One combinational sub-module, op_class_decoder: maps opcode/funct3 to class, imm_src, alu_src and alu_op.
- FSM, wait counter and fault flag stay in multicycle_ctrl.

Test Plan:
- ADDI (0010011, f3=000), rdy always 1 -> mem_req 1 cycle, ir_wr_en pulse; EXEC imm_src=000, alu_op=10, alu_src=1; WB reg_wr_en=1, pc_wr_en=1, pc_src=0; 4 cycles total.
- LW with rdy delayed 3 cycles in MEM -> mem_req/adr_src=1 held stable 4 cycles, mem_we=0; WB result_src=1; 8 cycles total.
- BEQ zero_i=1 -> pc_src=1 in EXEC. BNE (f3=001) zero_i=1 -> pc_src=0. Neither asserts reg_wr_en.
- SLLI (f3=001) -> imm_src=101. SW -> mem_we=1 in MEM, imm_src=001, no reg_wr_en.
- Opcode 1111111 -> FAULT after DECODE, fault_o=1 sticky for 20 cycles; rst_n_i pulse returns to FETCH with fault_o=0.
- FETCH with rdy held 0 -> after MEM_TIMEOUT+1 cycles fault_o=1, mem_req_o=0. Repeat with rdy=1 exactly on the timeout cycle -> normal DECODE.
